// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the memory-mapped machine timer and the generic
//   load/store lane helper:
//     - register byte offsets inside the 24-byte timer window and the matching
//       word indices (addr[4:2]);
//     - mem_acc_mode_e, the RISC-V funct3 load/store width encoding;
//     - CTRL field positions, a packed view of the CTRL register and a helper
//       that renders it as the 32-bit word seen by software.
// -----------------------------------------------------------------------------
package timer_pkg;

    // Byte offsets of the registers relative to BASE
    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_STATUS      = 5'h14;
    // First offset past the window; addresses at or above this miss
    localparam logic [4:0] OFF_END         = 5'h18;

    // Word indices (addr[4:2]) derived from the byte offsets
    localparam logic [2:0] IDX_MTIME_LO    = OFF_MTIME_LO[4:2];
    localparam logic [2:0] IDX_MTIME_HI    = OFF_MTIME_HI[4:2];
    localparam logic [2:0] IDX_MTIMECMP_LO = OFF_MTIMECMP_LO[4:2];
    localparam logic [2:0] IDX_MTIMECMP_HI = OFF_MTIMECMP_HI[4:2];
    localparam logic [2:0] IDX_CTRL        = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_STATUS      = OFF_STATUS[4:2];

    // RISC-V funct3 load/store width encoding
    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } mem_acc_mode_e;

    // CTRL field positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_PRESC_LSB  = 8;
    localparam int unsigned CTRL_PRESC_MSB  = 15;

    // Only the implemented CTRL bits are stored
    typedef struct packed {
        logic [7:0] presc;
        logic       irq_en;
        logic       en;
    } ctrl_t;

    // Software view of CTRL; unimplemented bits read as zero
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]                     = c.en;
        w[CTRL_IRQ_EN_BIT]                 = c.irq_en;
        w[CTRL_PRESC_MSB:CTRL_PRESC_LSB]   = c.presc;
        return w;
    endfunction

    // Inverse of ctrl_to_word for a fully merged store word
    function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
        ctrl_t c;
        c.en     = w[CTRL_EN_BIT];
        c.irq_en = w[CTRL_IRQ_EN_BIT];
        c.presc  = w[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        return c;
    endfunction

endpackage

// File: rtl/mmio_lane.sv
// -----------------------------------------------------------------------------
// mmio_lane
//   Purely combinational byte-lane helper for 32-bit memory-mapped registers.
//   Given the access width (funct3) and the byte lane addr[1:0] it:
//     - extracts the addressed byte/half/word from a 32-bit register word and
//       sign- or zero-extends it for loads;
//     - merges right-aligned store data into the addressed lanes of a word,
//       leaving the other bytes untouched;
//     - flags misaligned accesses and widths that are not B/H/W/BU/HU.
//
//   Ports
//     i_mode        funct3 access width
//     i_lane        byte lane, addr[1:0]
//     i_load_word   register word that loads read from
//     i_store_word  current register word that stores merge into
//     i_wdata       right-aligned store data (rs2)
//     o_load_data   extended load result (valid only for legal accesses)
//     o_merged_word i_store_word with the stored lanes replaced
//     o_misaligned  half not on an even byte, or word not on lane 0
//     o_illegal     width encoding outside the five supported modes
// -----------------------------------------------------------------------------
module mmio_lane
    import timer_pkg::*;
(
    input  logic [2:0]  i_mode,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_store_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word,
    output logic        o_misaligned,
    output logic        o_illegal
);

    mem_acc_mode_e w_mode;
    logic          w_is_byte;
    logic          w_is_half;
    logic          w_is_word;
    logic          w_is_signed;
    logic [4:0]    w_shamt;
    logic [31:0]   w_shifted;
    logic [3:0]    w_byte_en;
    logic [31:0]   w_bit_mask;
    logic [31:0]   w_wdata_sh;

    assign w_mode  = mem_acc_mode_e'(i_mode);
    assign w_shamt = {i_lane, 3'b000};

    // Width decode
    always_comb begin
        w_is_byte   = 1'b0;
        w_is_half   = 1'b0;
        w_is_word   = 1'b0;
        w_is_signed = 1'b0;
        case (w_mode)
            MODE_B:  begin w_is_byte = 1'b1; w_is_signed = 1'b1; end
            MODE_H:  begin w_is_half = 1'b1; w_is_signed = 1'b1; end
            MODE_W:  begin w_is_word = 1'b1; end
            MODE_BU: begin w_is_byte = 1'b1; end
            MODE_HU: begin w_is_half = 1'b1; end
            default: ;
        endcase
    end

    assign o_illegal    = ~(w_is_byte | w_is_half | w_is_word);
    assign o_misaligned = (w_is_half & i_lane[0]) | (w_is_word & (i_lane != 2'b00));

    // Load path: bring the addressed lane down to bit 0, then extend
    assign w_shifted = i_load_word >> w_shamt;

    always_comb begin
        o_load_data = '0;
        if (w_is_byte) begin
            o_load_data = {{24{w_is_signed & w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_is_half) begin
            o_load_data = {{16{w_is_signed & w_shifted[15]}}, w_shifted[15:0]};
        end else if (w_is_word) begin
            o_load_data = w_shifted;
        end
    end

    // Store path: byte enables shifted into place, then a masked merge
    always_comb begin
        w_byte_en = 4'b0000;
        if (w_is_byte) begin
            w_byte_en = 4'b0001 << i_lane;
        end else if (w_is_half) begin
            w_byte_en = 4'b0011 << i_lane;
        end else if (w_is_word) begin
            w_byte_en = 4'b1111;
        end
    end

    always_comb begin
        w_bit_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_bit_mask[8*i +: 8] = {8{w_byte_en[i]}};
        end
    end

    assign w_wdata_sh    = i_wdata << w_shamt;
    assign o_merged_word = (i_store_word & ~w_bit_mask) | (w_wdata_sh & w_bit_mask);

endmodule

// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
//   Memory-mapped machine timer on the data-side load/store bus. Holds a
//   64-bit prescaled free-running counter (mtime), a 64-bit compare register
//   (mtimecmp), CTRL (EN, IRQ_EN, PRESC) and a read-only STATUS bit, and drives
//   a registered level interrupt when IRQ_EN and mtime >= mtimecmp.
//
//   Window BASE..BASE+0x17:
//     0x00 MTIME_LO   0x04 MTIME_HI (reads return the snapshot taken by the
//     last MTIME_LO load)   0x08/0x0C MTIMECMP_LO/HI   0x10 CTRL   0x14 STATUS
//
//   Ports
//     clk             single clock, rising edge
//     rst             asynchronous active-low reset
//     rd_en / wr_en   load / store strobes for this cycle
//     addr            byte address
//     mem_acc_mode    funct3 width: B, H, W, BU, HU
//     wdata           right-aligned store data
//     rdata           combinational load data, zero when not a legal hit load
//     hit             addr lies inside the register window
//     acc_err         hit with an access that is misaligned or illegal width
//     timer_interrupt registered interrupt level
// -----------------------------------------------------------------------------
module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        acc_err,
    output logic        timer_interrupt
);

    // Architectural state
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    ctrl_t       r_ctrl;
    logic [7:0]  r_presc_cnt;
    logic [31:0] r_shadow_hi;
    logic        r_irq;

    // Decode
    logic [2:0]  w_idx;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_bad;
    logic        w_ld_ok;
    logic        w_st_ok;
    logic        w_cmp_ge;

    // Datapath
    logic [31:0] w_load_word;
    logic [31:0] w_store_word;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;
    logic        w_tick;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_mtimecmp_nxt;
    ctrl_t       w_ctrl_nxt;
    logic [7:0]  w_presc_nxt;
    logic [31:0] w_shadow_nxt;

    assign hit   = (addr[31:5] == BASE[31:5]) && (addr[4:0] < OFF_END);
    assign w_idx = addr[4:2];

    mmio_lane u_lane (
        .i_mode        (mem_acc_mode),
        .i_lane        (addr[1:0]),
        .i_load_word   (w_load_word),
        .i_store_word  (w_store_word),
        .i_wdata       (wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged),
        .o_misaligned  (w_misaligned),
        .o_illegal     (w_illegal)
    );

    assign w_bad    = w_misaligned | w_illegal;
    assign acc_err  = hit & (rd_en | wr_en) & w_bad;
    assign w_ld_ok  = hit & rd_en & ~w_bad;
    assign w_st_ok  = hit & wr_en & ~w_bad;
    assign w_cmp_ge = (r_mtime >= r_mtimecmp);

    // Load view: MTIME_HI reads come from the snapshot for coherent 64-bit reads
    always_comb begin
        w_load_word = '0;
        case (w_idx)
            IDX_MTIME_LO:    w_load_word = r_mtime[31:0];
            IDX_MTIME_HI:    w_load_word = r_shadow_hi;
            IDX_MTIMECMP_LO: w_load_word = r_mtimecmp[31:0];
            IDX_MTIMECMP_HI: w_load_word = r_mtimecmp[63:32];
            IDX_CTRL:        w_load_word = ctrl_to_word(r_ctrl);
            IDX_STATUS:      w_load_word = {31'b0, w_cmp_ge};
            default:         w_load_word = '0;
        endcase
    end

    // Store view: partial stores merge into the live register contents
    always_comb begin
        w_store_word = '0;
        case (w_idx)
            IDX_MTIME_LO:    w_store_word = r_mtime[31:0];
            IDX_MTIME_HI:    w_store_word = r_mtime[63:32];
            IDX_MTIMECMP_LO: w_store_word = r_mtimecmp[31:0];
            IDX_MTIMECMP_HI: w_store_word = r_mtimecmp[63:32];
            IDX_CTRL:        w_store_word = ctrl_to_word(r_ctrl);
            default:         w_store_word = '0;
        endcase
    end

    // Combinational read data shows the pre-store value on a read+write cycle
    assign rdata = w_ld_ok ? w_load_data : '0;

    // Prescaler
    assign w_tick = r_ctrl.en && (r_presc_cnt == r_ctrl.presc);

    always_comb begin
        w_presc_nxt = r_presc_cnt + 8'd1;
        if (w_st_ok && (w_idx == IDX_CTRL)) begin
            w_presc_nxt = '0;
        end else if (!r_ctrl.en || w_tick) begin
            w_presc_nxt = '0;
        end
    end

    // mtime: a store overrides the tick; the untouched word keeps its
    // pre-tick value so no carry leaks across the written half.
    always_comb begin
        w_mtime_nxt = w_tick ? (r_mtime + 64'd1) : r_mtime;
        if (w_st_ok && (w_idx == IDX_MTIME_LO)) begin
            w_mtime_nxt = {r_mtime[63:32], w_merged};
        end else if (w_st_ok && (w_idx == IDX_MTIME_HI)) begin
            w_mtime_nxt = {w_merged, r_mtime[31:0]};
        end
    end

    always_comb begin
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_st_ok && (w_idx == IDX_MTIMECMP_LO)) begin
            w_mtimecmp_nxt[31:0] = w_merged;
        end else if (w_st_ok && (w_idx == IDX_MTIMECMP_HI)) begin
            w_mtimecmp_nxt[63:32] = w_merged;
        end
    end

    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_st_ok && (w_idx == IDX_CTRL)) begin
            w_ctrl_nxt = word_to_ctrl(w_merged);
        end
    end

    // Any legal load of MTIME_LO (any width) snapshots the upper word
    always_comb begin
        w_shadow_nxt = r_shadow_hi;
        if (w_ld_ok && (w_idx == IDX_MTIME_LO)) begin
            w_shadow_nxt = r_mtime[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime     <= '0;
            r_mtimecmp  <= '1;
            r_ctrl      <= '0;
            r_presc_cnt <= '0;
            r_shadow_hi <= '0;
        end else begin
            r_mtime     <= w_mtime_nxt;
            r_mtimecmp  <= w_mtimecmp_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_presc_cnt <= w_presc_nxt;
            r_shadow_hi <= w_shadow_nxt;
        end
    end

    // Interrupt sampled from pre-edge register values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl.irq_en & w_cmp_ge;
        end
    end

    assign timer_interrupt = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [2:0]  MB  = 3'b000;
    localparam logic [2:0]  MH  = 3'b001;
    localparam logic [2:0]  MW  = 3'b010;
    localparam logic [2:0]  MBU = 3'b100;
    localparam logic [2:0]  MHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [2:0]  mem_acc_mode;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        acc_err;
    logic        timer_interrupt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_timer #(.BASE(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .mem_acc_mode    (mem_acc_mode),
        .wdata           (wdata),
        .rdata           (rdata),
        .hit             (hit),
        .acc_err         (acc_err),
        .timer_interrupt (timer_interrupt)
    );

    // ---------------- reference model (byte-addressed view) ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic        m_ie;
    logic [7:0]  m_presc;
    logic [7:0]  m_pcnt;
    logic [31:0] m_shadow;
    logic        m_irq;

    task automatic m_reset();
        m_mtime  = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en     = 1'b0;
        m_ie     = 1'b0;
        m_presc  = 8'd0;
        m_pcnt   = 8'd0;
        m_shadow = 32'd0;
        m_irq    = 1'b0;
    endtask

    function automatic int m_size(input logic [2:0] md);
        case (md)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd24);
    endfunction

    function automatic logic m_bad(input logic [31:0] a, input logic [2:0] md);
        int sz;
        sz = m_size(md);
        if (sz == 0) return 1'b1;
        return (a % 32'(sz)) != 32'd0;
    endfunction

    function automatic logic [7:0] m_view_byte(input int off);
        logic [31:0] w;
        case (off / 4)
            0:       w = m_mtime[31:0];
            1:       w = m_shadow;
            2:       w = m_cmp[31:0];
            3:       w = m_cmp[63:32];
            4:       w = {16'h0, m_presc, 6'h0, m_ie, m_en};
            5:       w = {31'h0, (m_mtime >= m_cmp)};
            default: w = 32'h0;
        endcase
        return w[8*(off%4) +: 8];
    endfunction

    function automatic logic [31:0] m_rdata(input logic r, input logic [31:0] a, input logic [2:0] md);
        logic [31:0] v;
        int sz;
        int off;
        if (!(r && m_in_window(a) && !m_bad(a, md))) return 32'h0;
        sz  = m_size(md);
        off = int'(a - BASE);
        v   = 32'h0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = m_view_byte(off + k);
        if ((md == MB || md == MH) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        return v;
    endfunction

    task automatic m_step(input logic r, input logic w, input logic [31:0] a,
                          input logic [2:0] md, input logic [31:0] wd);
        logic        ld_ok, st_ok, tick, n_irq;
        logic [63:0] n_mtime;
        logic [7:0]  n_pcnt, b;
        logic [31:0] n_shadow;
        int          off, sz, o;
        sz    = m_size(md);
        ld_ok = m_in_window(a) && r && !m_bad(a, md);
        st_ok = m_in_window(a) && w && !m_bad(a, md);
        off   = int'(a - BASE);
        tick  = m_en && (m_pcnt == m_presc);
        n_mtime  = tick ? m_mtime + 64'd1 : m_mtime;
        n_pcnt   = (!m_en || tick) ? 8'd0 : m_pcnt + 8'd1;
        n_irq    = m_ie && (m_mtime >= m_cmp);
        n_shadow = (ld_ok && off < 4) ? m_mtime[63:32] : m_shadow;
        if (st_ok) begin
            if (off < 8) n_mtime = m_mtime;
            for (int k = 0; k < sz; k++) begin
                b = wd[8*k +: 8];
                o = off + k;
                if (o < 8)        n_mtime[8*o +: 8] = b;
                else if (o < 16)  m_cmp[8*(o-8) +: 8] = b;
                else if (o == 16) begin m_en = b[0]; m_ie = b[1]; end
                else if (o == 17) m_presc = b;
            end
            if (off >= 16 && off < 20) n_pcnt = 8'd0;
        end
        m_mtime  = n_mtime;
        m_pcnt   = n_pcnt;
        m_shadow = n_shadow;
        m_irq    = n_irq;
    endtask

    // ---------------- checking and bus helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic r, input logic w, input logic [31:0] a,
                      input logic [2:0] md, input logic [31:0] wd,
                      output logic [31:0] o_rd, output logic o_hit, output logic o_err);
        logic        e_hit, e_err;
        logic [31:0] e_rd;
        @(negedge clk);
        rd_en = r; wr_en = w; addr = a; mem_acc_mode = md; wdata = wd;
        #1;
        e_hit = m_in_window(a);
        e_err = e_hit && (r || w) && m_bad(a, md);
        e_rd  = m_rdata(r, a, md);
        chk({tag, ".hit"},   64'(hit),             64'(e_hit));
        chk({tag, ".err"},   64'(acc_err),         64'(e_err));
        chk({tag, ".rdata"}, 64'(rdata),           64'(e_rd));
        chk({tag, ".irq"},   64'(timer_interrupt), 64'(m_irq));
        o_rd = rdata; o_hit = hit; o_err = acc_err;
        @(posedge clk);
        m_step(r, w, a, md, wd);
        #1;
    endtask

    task automatic idle(input int n);
        logic [31:0] d; logic h, e;
        for (int i = 0; i < n; i++) op("idle", 1'b0, 1'b0, BASE, MW, 32'h0, d, h, e);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] x; logic h, e;
        op("sw", 1'b0, 1'b1, a, MW, d, x, h, e);
    endtask

    task automatic lw(input logic [31:0] a, output logic [31:0] d);
        logic h, e;
        op("lw", 1'b1, 1'b0, a, MW, 32'h0, d, h, e);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        logic        h, e, seen;
        int          n;
        logic        r, w;
        logic [31:0] a;
        logic [2:0]  md;

        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; mem_acc_mode = MW; wdata = '0;
        m_reset();
        #12 rst = 1'b1;

        // Reset values
        chk("rst_irq", 64'(timer_interrupt), 64'd0);
        lw(BASE + 32'h00, d); chk("rst_mtime_lo", 64'(d), 64'h0);
        lw(BASE + 32'h04, d); chk("rst_mtime_hi", 64'(d), 64'h0);
        lw(BASE + 32'h08, d); chk("rst_cmp_lo",   64'(d), 64'hFFFF_FFFF);
        lw(BASE + 32'h0C, d); chk("rst_cmp_hi",   64'(d), 64'hFFFF_FFFF);
        lw(BASE + 32'h10, d); chk("rst_ctrl",     64'(d), 64'h0);
        lw(BASE + 32'h14, d); chk("rst_status",   64'(d), 64'h0);

        // Prescaler: PRESC=3, EN -> one tick every 4 cycles
        sw(BASE + 32'h10, 32'h0000_0301);
        idle(40);
        lw(BASE + 32'h00, d); chk("presc_mtime", 64'(d), 64'd10);

        // Interrupt rise/fall timing
        sw(BASE + 32'h10, 32'h0);
        sw(BASE + 32'h00, 32'h0);
        sw(BASE + 32'h04, 32'h0);
        sw(BASE + 32'h0C, 32'h0);
        sw(BASE + 32'h08, 32'd20);
        sw(BASE + 32'h10, 32'h3);
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            idle(1);
            n++;
            seen = timer_interrupt;
        end
        chk("irq_rise_seen",   64'(seen), 64'd1);
        chk("irq_rise_cycles", 64'(n),    64'd21);
        lw(BASE + 32'h00, d); chk("irq_rise_mtime", 64'(d), 64'd21);
        sw(BASE + 32'h08, 32'h0000_FFFF);
        chk("irq_hold_after_cmp_wr", 64'(timer_interrupt), 64'd1);
        idle(1);
        chk("irq_fall", 64'(timer_interrupt), 64'd0);

        // Wrap from all-ones
        sw(BASE + 32'h10, 32'h0);
        sw(BASE + 32'h00, 32'hFFFF_FFFF);
        sw(BASE + 32'h04, 32'hFFFF_FFFF);
        sw(BASE + 32'h10, 32'h1);
        idle(1);
        lw(BASE + 32'h00, d); chk("wrap_lo", 64'(d), 64'h0);
        lw(BASE + 32'h04, d); chk("wrap_hi", 64'(d), 64'h0);

        // Coherent snapshot across a low-word carry
        sw(BASE + 32'h10, 32'h0);
        sw(BASE + 32'h04, 32'h0);
        sw(BASE + 32'h00, 32'hFFFF_FFFF);
        sw(BASE + 32'h10, 32'h1);
        lw(BASE + 32'h00, d); chk("snap_lo",  64'(d), 64'hFFFF_FFFF);
        lw(BASE + 32'h04, d); chk("snap_hi",  64'(d), 64'h0);
        lw(BASE + 32'h00, d); chk("snap_lo2", 64'(d), 64'h1);
        lw(BASE + 32'h04, d); chk("snap_hi2", 64'(d), 64'h1);

        // Byte/half merges and extension
        sw(BASE + 32'h10, 32'h0);
        sw(BASE + 32'h08, 32'hFFFF_FFFF);
        op("sb", 1'b0, 1'b1, BASE + 32'h09, MB, 32'h1234_56AB, d, h, e);
        lw(BASE + 32'h08, d); chk("sb_merge", 64'(d), 64'hFFFF_ABFF);
        op("lb",  1'b1, 1'b0, BASE + 32'h09, MB,  32'h0, d, h, e); chk("lb",  64'(d), 64'hFFFF_FFAB);
        op("lbu", 1'b1, 1'b0, BASE + 32'h09, MBU, 32'h0, d, h, e); chk("lbu", 64'(d), 64'h0000_00AB);
        op("sh", 1'b0, 1'b1, BASE + 32'h0E, MH, 32'h1234_BEEF, d, h, e);
        op("lhu", 1'b1, 1'b0, BASE + 32'h0E, MHU, 32'h0, d, h, e); chk("lhu", 64'(d), 64'h0000_BEEF);
        op("lh",  1'b1, 1'b0, BASE + 32'h0E, MH,  32'h0, d, h, e); chk("lh",  64'(d), 64'hFFFF_BEEF);

        // Misalignment, illegal width, window edge, read+write
        op("lh_mis", 1'b1, 1'b0, BASE + 32'h01, MH, 32'h0, d, h, e);
        chk("lh_mis_err", 64'(e), 64'd1); chk("lh_mis_rdata", 64'(d), 64'h0);
        op("sw_mis", 1'b0, 1'b1, BASE + 32'h0A, MW, 32'hDEAD_BEEF, d, h, e);
        chk("sw_mis_err", 64'(e), 64'd1);
        lw(BASE + 32'h08, d); chk("sw_mis_unchanged", 64'(d), 64'hFFFF_ABFF);
        op("ill_mode", 1'b1, 1'b0, BASE + 32'h08, 3'b011, 32'h0, d, h, e);
        chk("ill_mode_err", 64'(e), 64'd1);
        op("miss", 1'b1, 1'b0, BASE + 32'h18, MW, 32'h0, d, h, e);
        chk("miss_hit", 64'(h), 64'd0); chk("miss_rdata", 64'(d), 64'h0);
        op("edge", 1'b1, 1'b0, BASE + 32'h17, MBU, 32'h0, d, h, e);
        chk("edge_hit", 64'(h), 64'd1);
        op("rw", 1'b1, 1'b1, BASE + 32'h08, MW, 32'h0000_0055, d, h, e);
        chk("rw_prestore", 64'(d), 64'hFFFF_ABFF);
        lw(BASE + 32'h08, d); chk("rw_stored", 64'(d), 64'h55);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) begin
                sw(BASE + 32'h04, 32'h0);
                sw(BASE + 32'h00, $urandom_range(0, 40));
                sw(BASE + 32'h0C, 32'h0);
                sw(BASE + 32'h08, $urandom_range(0, 80));
                sw(BASE + 32'h10, ($urandom_range(0, 2) << 8) | 32'h3);
            end
            r  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) == 0);
            md = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : BASE + $urandom_range(0, 31);
            op("rand", r, w, a, md, $urandom, d, h, e);
        end

        // Asynchronous reset while counting with the interrupt active
        sw(BASE + 32'h0C, 32'h0);
        sw(BASE + 32'h08, 32'd2);
        sw(BASE + 32'h10, 32'h3);
        idle(5);
        chk("pre_reset_irq", 64'(timer_interrupt), 64'd1);
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; addr = BASE; mem_acc_mode = MW;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_irq",   64'(timer_interrupt), 64'd0);
        chk("async_rst_rdata", 64'(rdata),           64'h0);
        m_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        lw(BASE + 32'h00, d); chk("post_rst_lo", 64'(d), 64'h0);
        idle(3);
        lw(BASE + 32'h00, d); chk("post_rst_hold", 64'(d), 64'h0);
        lw(BASE + 32'h08, d); chk("post_rst_cmp",  64'(d), 64'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped machine timer responding to the processor's data-side load/store interface (rd_en, wr_en, addr, mem_acc_mode, store data) and driving timer_interrupt back into the core's CSR/trap path. It holds a 64-bit prescaled free-running counter (mtime), a 64-bit compare register (mtimecmp) and a control register. It sits beside data_mem on the same address bus, and the top-level writeback path selects its read data when `hit` is high.

## Interface
- `BASE`, 32'h0000_2000: base address, 32-byte aligned; window is BASE..BASE+0x17.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `rd_en`  input  1: load strobe for the current cycle.
- `wr_en`  input  1: store strobe for the current cycle.
- `addr`  input  32: byte address, the ALU result.
- `mem_acc_mode`  input  3: RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `wdata`  input  32: store data, the rs2 value, right-aligned.
- `rdata`  output  32: load data, combinational, extended per mode.
- `hit`  output  1: addr falls in the register window (combinational).
- `acc_err`  output  1: hit with (rd_en|wr_en) and misaligned, or an illegal mode (combinational).
- `timer_interrupt`  output  1: registered level interrupt.

## Operation
- Register offsets:
  - 0x00 MTIME_LO.
  - 0x04 MTIME_HI.
  - 0x08 MTIMECMP_LO.
  - 0x0C MTIMECMP_HI.
  - 0x10 CTRL: bit0 EN, bit1 IRQ_EN, bits 15:8 PRESC; other bits read 0.
  - 0x14 STATUS: bit0 = mtime >= mtimecmp; read-only, writes ignored.
- Decode:
  - `hit` = addr[31:5]==BASE[31:5] and addr[4:0] < 0x18.
  - Register index = addr[4:2]; byte lane = addr[1:0].
- Alignment:
  - H requires addr[0]==0; W requires addr[1:0]==0.
  - Misaligned or illegal-mode access: no register change, rdata = 0, acc_err = 1.
- Loads:
  - Select the addressed 32-bit word and shift the lane down.
  - B/H sign-extend; BU/HU zero-extend.
  - rdata = 0 when !hit or !rd_en.
- Stores:
  - Byte/half/word merge into the addressed lanes only; other bytes are preserved.
  - SB uses wdata[7:0]; SH uses wdata[15:0].
- Shadow snapshot:
  - A load touching MTIME_LO copies mtime[63:32] into shadow_hi at the edge.
  - Loads of MTIME_HI return shadow_hi, giving a coherent 64-bit read as LO then HI.
  - shadow_hi resets to 0.
- Prescaler:
  - 8-bit presc_cnt; when EN=1, tick when presc_cnt==PRESC, then presc_cnt <= 0; otherwise presc_cnt increments.
  - PRESC=0 gives a tick every cycle.
  - EN=0 holds presc_cnt at 0.
  - Any CTRL write clears presc_cnt.
- Counter:
  - mtime += 1 on each tick and wraps from 2^64-1 to 0.
  - A store to MTIME_LO/HI in the same cycle as a tick: the stored bytes win; the other word keeps its pre-tick value with no carry.
- Compare:
  - Unsigned 64-bit comparison.
  - timer_interrupt <= IRQ_EN & (mtime >= mtimecmp), sampled from register values before the edge.
- Reset values:
  - mtime 0; mtimecmp all-ones; CTRL 0; presc_cnt 0; shadow_hi 0; timer_interrupt 0.
- rd_en and wr_en both high: the store is performed and rdata shows the pre-store value.

## Timing
- Loads have 0-cycle latency; rdata is valid in the same cycle as rd_en, as the single-cycle core requires.
- Stores are visible to loads from the next cycle.
- Interrupt latency:
  - timer_interrupt rises one edge after mtime >= mtimecmp first holds with IRQ_EN=1.
  - It falls one edge after the condition clears (mtimecmp rewritten higher, IRQ_EN cleared, or mtime wrap).
- Reset asserted mid-count clears all state immediately (asynchronous); counting resumes only after software sets EN.

## Structure
- Package `timer_pkg` holds:
  - offset localparams (OFF_MTIME_LO … OFF_STATUS);
  - the `mem_acc_mode_e` enum (B, H, W, BU, HU);
  - CTRL bit/field positions.
- Sub-module `mmio_lane` (combinational): store byte-merge and load extract/extend plus the misalignment check.
  - Reusable by data_mem and future peripherals.

## Test plan
- Reset, then read every register with LW → MTIME 0, MTIMECMP_LO/HI 0xFFFF_FFFF, CTRL 0, STATUS 0, timer_interrupt 0.
- SW CTRL=0x0000_0301 (PRESC=3, EN), wait 40 cycles → MTIME_LO == 10 (±1 by phase); presc_cnt never exceeds 3.
- SW MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=0x03 → timer_interrupt rises exactly one cycle after mtime reaches 20; SW MTIMECMP_LO=0xFFFF → it falls one cycle later.
- SW MTIME_LO=0xFFFF_FFFF, MTIME_HI=0xFFFF_FFFF, EN with PRESC=0 → next cycle mtime == 0; LW LO then LW HI returns the coherent snapshot, not a torn value.
- SB 0xAB to BASE+0x09 → MTIMECMP_LO == 0xFFFF_ABFF; LB BASE+0x09 → 0xFFFF_FFAB; LBU → 0x0000_00AB.
- LH at BASE+0x01 and SW at BASE+0x0A → acc_err=1, registers unchanged, rdata 0; addr BASE+0x18 → hit=0.
